// File: rtl/rx_unstuff_shift_pkg.sv
// Shared USB receive-path package: byte type and bit-framing constants
// used by the unstuff/shift stage and its stuffing detector.
package usb_rx_pkg;

    typedef logic [7:0] usb_byte_t;

    localparam int USB_STUFF_LIMIT = 6;
    localparam int USB_BYTE_BITS   = 8;

endpackage

// File: rtl/rx_unstuff_shift_if.sv
// Bit-stream and byte-output signals between the NRZI decoder / receive
// controller (master) and the unstuff/shift stage (slave).
interface rx_unstuff_shift_if
    import usb_rx_pkg::*;
;
    logic      shift_enable;
    logic      d_orig;
    logic      eop;
    logic      clear;
    usb_byte_t rx_data;
    logic      byte_ready;
    logic      stuff_err;

    modport master (
        output shift_enable, d_orig, eop, clear,
        input  rx_data, byte_ready, stuff_err
    );

    modport slave (
        input  shift_enable, d_orig, eop, clear,
        output rx_data, byte_ready, stuff_err
    );
endinterface

// File: rtl/rx_unstuff_shift_stuff_detect.sv
// Consecutive-ones tracker for USB bit unstuffing. Flags the bit slot that
// follows STUFF_LIMIT data ones as a stuff slot. Optional macro
// RX_STUFF_ERR_EN enables reporting of a 1 found in a stuff slot.
module stuff_detect
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LIMIT = USB_STUFF_LIMIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic shift_enable,
    input  logic eop,
    input  logic clear,
    input  logic d_orig,
    output logic is_stuff,
    output logic stuff_viol
);

    localparam int CNT_W = $clog2(STUFF_LIMIT + 1);

    logic [CNT_W-1:0] ones_cnt;

    assign is_stuff = (ones_cnt == CNT_W'(STUFF_LIMIT));

`ifdef RX_STUFF_ERR_EN
    assign stuff_viol = shift_enable & ~eop & ~clear & is_stuff & d_orig;
`else
    assign stuff_viol = 1'b0;
`endif

    // Run length of data ones; not reset at byte boundaries so stuffing spans bytes
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_cnt <= '0;
        end else if (clear) begin
            ones_cnt <= '0;
        end else if (shift_enable) begin
            if (eop || is_stuff || !d_orig) begin
                ones_cnt <= '0;
            end else begin
                ones_cnt <= ones_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_unstuff_shift.sv
// USB full-speed receive unstuff/shift stage: drops stuffed bits, assembles
// data bits LSB-first into bytes and pulses byte_ready per completed byte.
// Optional macro RX_STUFF_ERR_EN enables the sticky stuff_err flag; without
// it stuff_err is tied to 0.
module rx_unstuff_shift
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LIMIT = USB_STUFF_LIMIT
) (
    input  logic                clk,
    input  logic                n_rst,
    rx_unstuff_shift_if.slave   bus
);

    localparam int BIT_W = $clog2(USB_BYTE_BITS);

    usb_byte_t        shift_reg;
    usb_byte_t        shift_nxt;
    usb_byte_t        rx_data_q;
    logic [BIT_W-1:0] bit_cnt;
    logic             byte_ready_q;
    logic             stuff_err_q;
    logic             is_stuff;
    logic             data_bit;

`ifdef RX_STUFF_ERR_EN
    logic             stuff_viol;
`endif

    stuff_detect #(
        .STUFF_LIMIT (STUFF_LIMIT)
    ) u_stuff_detect (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (bus.shift_enable),
        .eop          (bus.eop),
        .clear        (bus.clear),
        .d_orig       (bus.d_orig),
        .is_stuff     (is_stuff),
`ifdef RX_STUFF_ERR_EN
        .stuff_viol   (stuff_viol)
`else
        .stuff_viol   ()
`endif
    );

    assign shift_nxt = {bus.d_orig, shift_reg[USB_BYTE_BITS-1:1]};
    assign data_bit  = bus.shift_enable & ~bus.eop & ~is_stuff;

    // Byte assembly and output byte register; clear beats eop beats data
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            rx_data_q    <= '0;
            byte_ready_q <= 1'b0;
        end else begin
            byte_ready_q <= 1'b0;
            if (bus.clear) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (bus.shift_enable && bus.eop) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (data_bit) begin
                shift_reg <= shift_nxt;
                if (bit_cnt == BIT_W'(USB_BYTE_BITS - 1)) begin
                    bit_cnt      <= '0;
                    rx_data_q    <= shift_nxt;
                    byte_ready_q <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

`ifdef RX_STUFF_ERR_EN
    // Sticky violation flag, only released by clear or reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stuff_err_q <= 1'b0;
        end else if (bus.clear) begin
            stuff_err_q <= 1'b0;
        end else if (stuff_viol) begin
            stuff_err_q <= 1'b1;
        end
    end
`else
    assign stuff_err_q = 1'b0;
`endif

    assign bus.rx_data    = rx_data_q;
    assign bus.byte_ready = byte_ready_q;
    assign bus.stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_rx_unstuff_shift.sv
// Scoreboard bench for rx_unstuff_shift: directed bit sequences push the
// hand-computed expected bytes; a negedge monitor pops on every byte_ready.
module tb_rx_unstuff_shift;
    import usb_rx_pkg::*;

    logic clk = 1'b0;
    logic n_rst;
    int   n_checks = 0;
    int   n_err    = 0;
    usb_byte_t exp_q[$];

`ifdef RX_STUFF_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    rx_unstuff_shift_if bus ();

    rx_unstuff_shift #(.STUFF_LIMIT(USB_STUFF_LIMIT)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: inputs set just after an edge, sampled at the next
    task automatic drive(input logic se, input logic d, input logic e, input logic c);
        bus.shift_enable = se;
        bus.d_orig       = d;
        bus.eop          = e;
        bus.clear        = c;
        @(posedge clk);
        #1;
        bus.shift_enable = 1'b0;
        bus.d_orig       = 1'b0;
        bus.eop          = 1'b0;
        bus.clear        = 1'b0;
    endtask

    // Bits go out in time order starting at bits[0]
    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, bits[i], 1'b0, 1'b0);
    endtask

    task automatic send_byte(input usb_byte_t v);
        exp_q.push_back(v);
        send_bits({8'h00, v}, 8);
    endtask

    // Monitor: every byte_ready must match the oldest expected byte
    always @(negedge clk) begin
        if (n_rst === 1'b1 && bus.byte_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_byte_ready: got rx_data %h expected no byte at %0t",
                         bus.rx_data, $time);
            end else begin
                check("rx_data", bus.rx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.shift_enable = 1'b0;
        bus.d_orig       = 1'b0;
        bus.eop          = 1'b0;
        bus.clear        = 1'b0;
        n_rst            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_byte_ready", {7'h0, bus.byte_ready}, 8'h00);
        check("reset_stuff_err", {7'h0, bus.stuff_err}, 8'h00);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Plain byte, LSB first: 1,0,1,0,0,1,0,1
        send_byte(8'hA5);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("a5_stuff_err", {7'h0, bus.stuff_err}, 8'h00);

        // Six 1s, stuff 0, two 1s -> FF; ones run of 2 carries into next byte
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'hFF);
        send_bits(16'h01BF, 9);
        // 1,1,1,1 completes run of 6, then stuff 0 dropped, then 1,0,0,0 -> 1F
        exp_q.push_back(8'h1F);
        send_bits(16'h002F, 9);

        // Seven 1s: the 7th lands in a stuff slot
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'h007F, 7);
        check("seven_ones_stuff_err", {7'h0, bus.stuff_err}, {7'h0, ERR_EXP});
        exp_q.push_back(8'h3F);
        send_bits(16'h0000, 2);
        check("stuff_err_sticky", {7'h0, bus.stuff_err}, {7'h0, ERR_EXP});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_stuff_err", {7'h0, bus.stuff_err}, 8'h00);

        // Partial byte aborted by eop, then a clean byte
        send_bits(16'h000B, 5);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        send_byte(8'h3C);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-byte
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'h000F, 4);
        #2;
        n_rst = 1'b0;
        #1;
        check("midreset_rx_data", bus.rx_data, 8'h00);
        check("midreset_byte_ready", {7'h0, bus.byte_ready}, 8'h00);
        check("midreset_stuff_err", {7'h0, bus.stuff_err}, 8'h00);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        send_byte(8'h81);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Clear coincident with a data strobe drops that bit; rx_data held
        send_bits(16'h0005, 3);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("clear_holds_rx_data", bus.rx_data, 8'h81);
        send_byte(8'h5A);

        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("pending_bytes", 8'(exp_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
